// File: rtl/matrix_lc_pkg.sv
// Shared types and constants for the playfield matrix with in-place line clear.
package matrix_lc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } matrix_lc_state_e;

  // Colour code of an empty cell; wide enough for any practical cell depth.
  localparam logic [7:0] cell_empty = 8'd0;

endpackage

// File: rtl/matrix_row_full.sv
// Combinational full-row detector: a row is full when no cell holds the empty code.
module matrix_row_full
  import matrix_lc_pkg::*;
#(
  parameter int width_p = 10,
  parameter int depth_p = 2
) (
  input  logic [width_p*depth_p-1:0] row,
  output logic                       full
);

  // Any empty cell disqualifies the row.
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < width_p; i++) begin
      if (row[i*depth_p +: depth_p] == cell_empty[depth_p-1:0]) begin
        full = 1'b0;
      end else begin
        full = full;
      end
    end
  end

endmodule

// File: rtl/matrix_lc.sv
// Playfield matrix register with row writes and a one-row-per-cycle line-clear pass
// that collapses surviving rows toward the bottom and zero-fills the top.
module matrix_lc
  import matrix_lc_pkg::*;
#(
  parameter int width_p  = 10,
  parameter int height_p = 20,
  parameter int depth_p  = 2
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [$clog2(height_p)-1:0]           set_row_addr_i,
  input  logic [width_p*depth_p-1:0]            set_row_data_i,
  input  logic                                  set_v_i,
  output logic                                  set_ready_o,
  input  logic                                  clear_start_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [$clog2(height_p+1)-1:0]         lines_cleared_o,
  output logic [height_p*width_p*depth_p-1:0]   matrix_o
);

  localparam int row_w = width_p * depth_p;
  localparam int ptr_w = $clog2(height_p);
  localparam int cnt_w = $clog2(height_p + 1);
  localparam logic [ptr_w-1:0] last_row = ptr_w'(height_p - 1);

  logic [height_p-1:0][row_w-1:0] mat;
  matrix_lc_state_e state, state_next;
  logic [ptr_w-1:0] rd_ptr, rd_next;
  logic [ptr_w-1:0] wr_ptr, wr_next;
  logic [cnt_w-1:0] count, count_next;
  logic [cnt_w-1:0] lines_cleared;
  logic             row_we;
  logic [ptr_w-1:0] row_addr;
  logic [row_w-1:0] row_data;
  logic             rd_full;

  matrix_row_full #(
    .width_p(width_p),
    .depth_p(depth_p)
  ) u_row_full (
    .row  (mat[rd_ptr]),
    .full (rd_full)
  );

  // Next-state, pointer and single row-write port selection.
  always_comb begin
    state_next = state;
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    count_next = count;
    row_we     = 1'b0;
    row_addr   = wr_ptr;
    row_data   = mat[rd_ptr];
    case (state)
      IDLE: begin
        if (set_v_i && (32'(set_row_addr_i) < height_p)) begin
          row_we   = 1'b1;
          row_addr = set_row_addr_i;
          row_data = set_row_data_i;
        end else begin
          row_we = 1'b0;
        end
        if (clear_start_i) begin
          rd_next    = last_row;
          wr_next    = last_row;
          count_next = '0;
          state_next = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      SCAN: begin
        // Full rows are skipped; survivors are copied down to wr_ptr.
        if (rd_full) begin
          count_next = count + cnt_w'(1);
        end else begin
          row_we   = 1'b1;
          row_addr = wr_ptr;
          row_data = mat[rd_ptr];
          wr_next  = (wr_ptr != '0) ? wr_ptr - ptr_w'(1) : wr_ptr;
        end
        if (rd_ptr == '0) begin
          state_next = (count_next != '0) ? FILL : DONE;
        end else begin
          rd_next = rd_ptr - ptr_w'(1);
        end
      end
      FILL: begin
        row_we   = 1'b1;
        row_addr = wr_ptr;
        row_data = '0;
        if (wr_ptr == '0) begin
          state_next = DONE;
        end else begin
          wr_next = wr_ptr - ptr_w'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, pointers, counters and matrix storage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      lines_cleared <= '0;
      mat           <= '0;
    end else begin
      state  <= state_next;
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      count  <= count_next;
      if (row_we) begin
        mat[row_addr] <= row_data;
      end
      if (state == DONE) begin
        lines_cleared <= count;
      end
    end
  end

  assign set_ready_o     = (state == IDLE);
  assign busy_o          = (state == SCAN) || (state == FILL);
  assign done_o          = (state == DONE);
  assign lines_cleared_o = lines_cleared;
  assign matrix_o        = mat;

endmodule

// File: tb/tb_matrix_lc.sv
// Randomized self-checking bench for matrix_lc against a row-list reference model.
module tb_matrix_lc;

  localparam int W = 10;
  localparam int H = 20;
  localparam int D = 2;
  localparam int RW = W * D;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    set_row_addr = '0;
  logic [RW-1:0] set_row_data = '0;
  logic          set_v = 1'b0;
  logic          set_ready;
  logic          clear_start = 1'b0;
  logic          busy;
  logic          done;
  logic [4:0]    lines_cleared;
  logic [H*RW-1:0] matrix;

  int nvec = 0;
  int nerr = 0;
  logic [RW-1:0] model [H];

  matrix_lc #(.width_p(W), .height_p(H), .depth_p(D)) dut (
    .clk_i(clk), .reset_i(reset),
    .set_row_addr_i(set_row_addr), .set_row_data_i(set_row_data), .set_v_i(set_v),
    .set_ready_o(set_ready), .clear_start_i(clear_start), .busy_o(busy), .done_o(done),
    .lines_cleared_o(lines_cleared), .matrix_o(matrix)
  );

  always #5 clk = ~clk;

  function automatic bit is_full(input logic [RW-1:0] r);
    for (int i = 0; i < W; i++) if (r[i*D +: D] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  // kind 0: full, 1: partial (at least one empty cell), 2: empty
  function automatic logic [RW-1:0] gen_row(input int kind);
    logic [RW-1:0] r;
    r = '0;
    if (kind == 0) begin
      for (int i = 0; i < W; i++) r[i*D +: D] = 2'($urandom_range(3, 1));
    end else if (kind == 1) begin
      for (int i = 0; i < W; i++) r[i*D +: D] = 2'($urandom_range(3, 0));
      r[$urandom_range(W-1, 0)*D +: D] = 2'b00;
    end
    return r;
  endfunction

  // Remove full rows, stack survivors at the bottom in order, blank the top.
  function automatic int model_clear();
    logic [RW-1:0] keep [$];
    int c = 0;
    for (int r = H-1; r >= 0; r--) begin
      if (is_full(model[r])) c++;
      else keep.push_back(model[r]);
    end
    for (int r = H-1; r >= 0; r--) begin
      model[r] = (H-1-r < keep.size()) ? keep[H-1-r] : '0;
    end
    return c;
  endfunction

  function automatic int first_diff();
    for (int r = 0; r < H; r++) if (matrix[r*RW +: RW] !== model[r]) return r;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    for (int r = 0; r < H; r++) model[r] = '0;
  endtask

  task automatic load_model();
    for (int r = 0; r < H; r++) begin
      @(negedge clk); set_v = 1'b1; set_row_addr = 5'(r); set_row_data = model[r];
    end
    @(negedge clk); set_v = 1'b0;
  endtask

  task automatic run_clear(input bit same_write, input logic [4:0] waddr,
                           input logic [RW-1:0] wdata, input int inject_at, output int cycles);
    @(negedge clk);
    clear_start = 1'b1;
    if (same_write) begin
      set_v = 1'b1; set_row_addr = waddr; set_row_data = wdata;
    end
    @(negedge clk); clear_start = 1'b0; set_v = 1'b0; cycles = 1;
    while (done !== 1'b1 && cycles < 200) begin
      if (cycles == inject_at) begin
        set_v = 1'b1; set_row_addr = waddr; set_row_data = wdata; clear_start = 1'b1;
      end
      @(negedge clk); set_v = 1'b0; clear_start = 1'b0; cycles++;
    end
  endtask

  task automatic test_reset();
    int fd;
    do_reset();
    nvec++; if (set_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", set_ready); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b exp 0", done); end
    nvec++; if (lines_cleared !== 5'd0) begin nerr++; $display("FAIL reset_lines got %0d exp 0", lines_cleared); end
    fd = first_diff();
    nvec++; if (fd != -1) begin nerr++; $display("FAIL reset_matrix row %0d got %h exp %h", fd, matrix[fd*RW +: RW], model[fd]); end
  endtask

  task automatic test_set_row();
    int fd;
    @(negedge clk); set_v = 1'b1; set_row_addr = 5'd5; set_row_data = 20'h55555;
    @(negedge clk); set_v = 1'b0;
    model[5] = 20'h55555;
    nvec++; if (matrix[5*RW +: RW] !== 20'h55555) begin nerr++; $display("FAIL set_row5 got %h exp 55555", matrix[5*RW +: RW]); end
    nvec++; if (busy !== 1'b0 || set_ready !== 1'b1) begin nerr++; $display("FAIL set_flags got busy=%b ready=%b exp 0/1", busy, set_ready); end
    for (int k = 0; k < 4; k++) begin
      int a = $urandom_range(H-1, 0);
      logic [RW-1:0] d = gen_row($urandom_range(1, 0));
      @(negedge clk); set_v = 1'b1; set_row_addr = 5'(a); set_row_data = d;
      @(negedge clk); set_v = 1'b0; model[a] = d;
      fd = first_diff();
      nvec++; if (fd != -1) begin nerr++; $display("FAIL set_rand row %0d got %h exp %h", fd, matrix[fd*RW +: RW], model[fd]); end
    end
  endtask

  task automatic check_pass(input string name, input int exp_lines, input int cycles);
    int fd;
    nvec++; if (cycles != 1 + H + exp_lines) begin nerr++; $display("FAIL %s_latency got %0d exp %0d", name, cycles, 1 + H + exp_lines); end
    @(negedge clk);
    nvec++; if (lines_cleared !== 5'(exp_lines)) begin nerr++; $display("FAIL %s_lines got %0d exp %0d", name, lines_cleared, exp_lines); end
    nvec++; if (done !== 1'b0 || set_ready !== 1'b1) begin nerr++; $display("FAIL %s_idle got done=%b ready=%b exp 0/1", name, done, set_ready); end
    fd = first_diff();
    nvec++; if (fd != -1) begin nerr++; $display("FAIL %s_matrix row %0d got %h exp %h", name, fd, matrix[fd*RW +: RW], model[fd]); end
  endtask

  task automatic test_scenarios();
    int cyc, c;
    do_reset();
    model[19] = gen_row(0); model[18] = gen_row(0); model[17] = 20'h00001;
    load_model(); c = model_clear(); run_clear(1'b0, '0, '0, 0, cyc);
    nvec++; if (c != 2 || cyc != 23) begin nerr++; $display("FAIL two_bottom got cyc=%0d exp 23 (model %0d)", cyc, c); end
    check_pass("two_bottom", 2, cyc);

    do_reset();
    model[19] = gen_row(0); model[17] = gen_row(0); model[18] = gen_row(1); model[16] = gen_row(1);
    load_model(); c = model_clear(); run_clear(1'b0, '0, '0, 0, cyc);
    check_pass("gap", c, cyc);

    for (int r = 0; r < H; r++) model[r] = gen_row(0);
    load_model(); c = model_clear(); run_clear(1'b0, '0, '0, 0, cyc);
    nvec++; if (cyc != 41) begin nerr++; $display("FAIL all_full_latency got %0d exp 41", cyc); end
    check_pass("all_full", 20, cyc);
  endtask

  task automatic test_random();
    int cyc, c;
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < H; r++) model[r] = gen_row($urandom_range(2, 0));
      load_model(); c = model_clear(); run_clear(1'b0, '0, '0, 0, cyc);
      check_pass("random", c, cyc);
    end
  endtask

  task automatic test_mid_scan();
    int cyc, c;
    for (int r = 0; r < H; r++) model[r] = gen_row($urandom_range(1, 0));
    model[0] = '0;
    load_model(); c = model_clear();
    run_clear(1'b0, 5'd0, 20'hFFFFF, 3, cyc);
    check_pass("mid_scan", c, cyc);
  endtask

  task automatic test_same_cycle();
    int cyc, c;
    logic [RW-1:0] fr;
    for (int r = 0; r < H; r++) model[r] = gen_row($urandom_range(2, 1));
    load_model();
    fr = gen_row(0); model[10] = fr; c = model_clear();
    run_clear(1'b1, 5'd10, fr, 0, cyc);
    check_pass("same_cycle", c, cyc);
  endtask

  task automatic test_reset_in_fill();
    int fd, cyc;
    bit seen;
    for (int r = 0; r < H; r++) model[r] = gen_row(0);
    load_model();
    @(negedge clk); clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0; cyc = 1;
    while (cyc < 24) begin @(negedge clk); cyc++; end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL fill_busy got %b exp 1", busy); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int r = 0; r < H; r++) model[r] = '0;
    fd = first_diff();
    nvec++; if (fd != -1) begin nerr++; $display("FAIL fill_reset_matrix row %0d got %h exp %h", fd, matrix[fd*RW +: RW], model[fd]); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL fill_reset_busy got %b exp 0", busy); end
    nvec++; if (lines_cleared !== 5'd0) begin nerr++; $display("FAIL fill_reset_lines got %0d exp 0", lines_cleared); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (done === 1'b1) seen = 1'b1; end
    nvec++; if (seen) begin nerr++; $display("FAIL fill_reset_done got pulse exp none"); end
  endtask

  initial begin
    test_reset();
    test_set_row();
    test_scenarios();
    test_random();
    test_mid_scan();
    test_same_cycle();
    test_reset_in_fill();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
